if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle core's instruction ROM.
- Owns the program counter and drives the ROM address; the ROM returns the word combinationally in the same cycle.
- Captures {pc, instr} pairs into a small FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump/trap) and halt requests.

---
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads the ROM and queues {pc, instr} for decode.
// Latency 1 cycle from fetch to out_valid; 1 instr/cycle sustained, stalls when FIFO is full and not popped.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise a sticky fetch_err.
module if_fetch_unit #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned   DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_instr,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pc_plus4,
  output logic          halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic          fetch_err,
  output logic [AW-1:0] fetch_err_pc
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_q;
  entry_t        mem [DEPTH];
  logic          push, pop, redir_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign redir_bad = 1'b0;
`endif

  assign imem_addr    = fetch_pc;
  assign out_valid    = (count_q != '0);
  assign out_pc       = mem[rd_ptr].pc;
  assign out_instr    = mem[rd_ptr].instr;
  assign out_pc_plus4 = out_pc + AW'(4);
  assign halted       = (state_q == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Redirect outranks halt, pop and push; a pop during a flush is simply discarded.
  always_comb begin
    state_d = state_q;
    pop     = out_valid & out_ready;
    push    = 1'b0;
    if (redirect_valid) begin
      state_d = redir_bad ? HALT : RUN;
    end else if (state_q == RUN) begin
      push = (count_q < FULL) | pop;
      if (halt_req) state_d = HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (redirect_valid) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      if (!redir_bad) fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr};
        wr_ptr      <= wr_ptr + PW'(1);
        fetch_pc    <= fetch_pc + AW'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky until an aligned redirect arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err    <= 1'b0;
      fetch_err_pc <= '0;
    end else if (redirect_valid) begin
      fetch_err <= redir_bad;
      if (redir_bad) fetch_err_pc <= redirect_pc;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic against a queue-level model.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_w = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        out_ready = 1'b0;

  logic [31:0] imem_addr, imem_instr, out_instr, out_pc, out_pc_plus4;
  logic        out_valid, halted;
  logic [31:0] w_imem_addr, w_imem_instr, w_out_instr, w_out_pc, w_out_pc_plus4;
  logic        w_out_valid, w_halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_err, w_fetch_err;
  logic [31:0] fetch_err_pc, w_fetch_err_pc;
`endif

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign imem_instr   = rom(imem_addr);
  assign w_imem_instr = rom(w_imem_addr);

  always #5 clk = ~clk;

  if_fetch_unit #(.AW(32), .DW(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_main (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .halted(halted)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_err(fetch_err), .fetch_err_pc(fetch_err_pc)
`endif
  );

  if_fetch_unit #(.AW(32), .DW(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc),
    .out_pc_plus4(w_out_pc_plus4), .halted(w_halted)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_err(w_fetch_err), .fetch_err_pc(w_fetch_err_pc)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model for u_main: a queue of fetched {pc, instr} plus the next fetch address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_err;
  logic [31:0] m_err_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  task automatic model_step();
    bit pop, push;
    if (redirect_valid) begin
      q.delete();
      if (MIS && redirect_pc[1:0] != 2'b00) begin
        m_halt = 1; m_err = 1; m_err_pc = redirect_pc;
      end else begin
        m_pc = redirect_pc & ~32'h3; m_halt = 0; m_err = 0;
      end
    end else begin
      pop  = (q.size() != 0) && out_ready;
      push = !m_halt && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_pc, instr: rom(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (halt_req) m_halt = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); m_pc = 32'h0; m_halt = 0; m_err = 0; m_err_pc = '0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %h want 0", out_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %h want 0", halted); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL rst_out_pc got %h want 0", out_pc); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
    n_cmp++; if (out_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_plus4 got %h want 4", out_pc_plus4); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_imem_addr got %h want 0", imem_addr); end
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_fetch_err got %h want 0", fetch_err); end
`endif
  endtask

  task automatic test_straight();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL straight_valid k=%0d got %h want 1", k, out_valid); end
      n_cmp++; if (out_pc !== 32'(4*(k-1))) begin n_err++; $display("FAIL straight_pc k=%0d got %h want %h", k, out_pc, 32'(4*(k-1))); end
      n_cmp++; if (out_instr !== 32'(k-1)) begin n_err++; $display("FAIL straight_instr k=%0d got %h want %h", k, out_instr, 32'(k-1)); end
      n_cmp++; if (imem_addr !== 32'(4*k)) begin n_err++; $display("FAIL straight_addr k=%0d got %h want %h", k, imem_addr, 32'(4*k)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    repeat (5) tick();
    n_cmp++; if (out_pc !== 32'h10) begin n_err++; $display("FAIL bp_start got %h want 10", out_pc); end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (out_pc !== 32'h10 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_pc k=%0d got %h/%h want 10/1", k, out_pc, out_valid); end
      n_cmp++; if (imem_addr !== 32'h18) begin n_err++; $display("FAIL bp_hold_addr k=%0d got %h want 18", k, imem_addr); end
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (out_pc !== 32'(32'h10 + 4*k) || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_release k=%0d got %h/%h want %h/1", k, out_pc, out_valid, 32'(32'h10 + 4*k)); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %h want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", imem_addr); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_err++; $display("FAIL redir_head got %h/%h want 1/100", out_valid, out_pc); end
    n_cmp++; if (out_pc_plus4 !== 32'h104) begin n_err++; $display("FAIL redir_plus4 got %h want 104", out_pc_plus4); end
    n_cmp++; if (out_instr !== 32'h40) begin n_err++; $display("FAIL redir_instr got %h want 40", out_instr); end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b1;
    repeat (8) tick();
    n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL halt_pre got %h want 20", imem_addr); end
    halt_req = 1'b1;
    tick();
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag got %h want 1", halted); end
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h20) begin n_err++; $display("FAIL halt_last got %h/%h want 1/20", out_valid, out_pc); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL halt_drain k=%0d got %h/%h want 0/1", k, out_valid, halted); end
      n_cmp++; if (imem_addr !== 32'h24) begin n_err++; $display("FAIL halt_frozen k=%0d got %h want 24", k, imem_addr); end
    end
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (halted !== 1'b0 || imem_addr !== 32'h40) begin n_err++; $display("FAIL halt_resume got %h/%h want 0/40", halted, imem_addr); end
    tick();
    n_cmp++; if (out_pc !== 32'h40 || out_instr !== 32'h10) begin n_err++; $display("FAIL halt_resume_head got %h/%h want 40/10", out_pc, out_instr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_w = 1'b0;
    tick();
    n_cmp++; if (w_out_valid !== 1'b1 || w_out_pc !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_0 got %h/%h want 1/fffffff8", w_out_valid, w_out_pc); end
    tick();
    n_cmp++; if (w_out_pc !== 32'hFFFF_FFFC || w_out_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_1 got %h/%h want fffffffc/0", w_out_pc, w_out_pc_plus4); end
    tick();
    n_cmp++; if (w_out_pc !== 32'h0 || w_out_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL wrap_2 got %h/%h want 0/4", w_out_pc, w_out_pc_plus4); end
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    halt_req = 1'b0; redirect_valid = 1'b0;
    n_cmp++; if (w_halted !== 1'b0 || w_out_valid !== 1'b0 || w_imem_addr !== 32'h80) begin n_err++; $display("FAIL coll_state got %h/%h/%h want 0/0/80", w_halted, w_out_valid, w_imem_addr); end
    tick();
    tick();
    n_cmp++; if (w_out_pc !== 32'h84 || w_halted !== 1'b0) begin n_err++; $display("FAIL coll_run got %h/%h want 84/0", w_out_pc, w_halted); end
    rst_w = 1'b1;
  endtask

  task automatic test_misalign();
    do_reset();
    out_ready = 1'b1;
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++; if (fetch_err !== 1'b1 || fetch_err_pc !== 32'h102) begin n_err++; $display("FAIL mis_err got %h/%h want 1/102", fetch_err, fetch_err_pc); end
    n_cmp++; if (halted !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mis_halt got %h/%h want 1/0", halted, out_valid); end
    repeat (2) tick();
    n_cmp++; if (fetch_err !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL mis_sticky got %h/%h want 1/0", fetch_err, out_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_err !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL mis_clear got %h/%h want 0/0", fetch_err, halted); end
    tick();
    n_cmp++; if (out_pc !== 32'h200 || out_valid !== 1'b1) begin n_err++; $display("FAIL mis_refetch got %h/%h want 200/1", out_pc, out_valid); end
`else
    n_cmp++; if (halted !== 1'b0 || imem_addr !== 32'h100) begin n_err++; $display("FAIL mask_addr got %h/%h want 0/100", halted, imem_addr); end
    tick();
    n_cmp++; if (out_pc !== 32'h100 || out_instr !== 32'h40) begin n_err++; $display("FAIL mask_head got %h/%h want 100/40", out_pc, out_instr); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      halt_req       = ($urandom_range(0, 39) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 4095));
      tick();
      n_cmp++; if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d got %h want %h", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if (out_pc !== q[0].pc || out_instr !== q[0].instr || out_pc_plus4 !== q[0].pc + 32'd4) begin
          n_err++; $display("FAIL rnd_head c=%0d got %h/%h/%h want %h/%h/%h", c, out_pc, out_instr, out_pc_plus4, q[0].pc, q[0].instr, q[0].pc + 32'd4);
        end
      end
      n_cmp++; if (imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_addr, m_pc); end
      n_cmp++; if (halted !== m_halt) begin n_err++; $display("FAIL rnd_halted c=%0d got %h want %h", c, halted, m_halt); end
`ifdef FETCH_MISALIGN_TRAP_EN
      n_cmp++; if (fetch_err !== m_err || (m_err && fetch_err_pc !== m_err_pc)) begin
        n_err++; $display("FAIL rnd_err c=%0d got %h/%h want %h/%h", c, fetch_err, fetch_err_pc, m_err, m_err_pc);
      end
`endif
    end
    redirect_valid = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0) begin
      n_err++; $display("FAIL rst_async got %h/%h/%h want 0/0/0", out_valid, imem_addr, halted);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_full();
    test_halt();
    test_wrap();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
